// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch PC generator.
//   XLEN          : architectural register / address width
//   OP_JAL/OP_JALR: major opcodes recognised by the control-flow predecoder
//   fetch_state_t : fetch FSM encoding (BOOT / RUN / DRAIN)
//   is_link()     : true for the RISC-V link registers x1 and x5
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Bundle of every non-clock/reset signal between the fetch PC generator and
// its surroundings (backend redirect, instruction memory, RAS, decode).
//   master : the PC generator (drives pc, RAS strobes, fetch packet, state)
//   slave  : the environment (drives stall, redirect, imem data, RAS top)
//
// Handshake: a fetch packet is handed to decode on every rising edge where
// the generator is in RUN, instr_valid is high, stall is low and
// redirect_valid is low. stall acts as the inverse of ready and freezes the
// packet registers; fetch_valid is the registered valid of that packet.
interface fetch_pc_gen_if;
    import riscv_pkg::*;

    // Environment -> generator
    logic             stall;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             instr_valid;
    logic [31:0]      imem_rdata;
    logic             ras_valid;
    logic [XLEN-1:0]  ras_predicted_return;

    // Generator -> environment
    logic [XLEN-1:0]  pc;
    logic             ras_push;
    logic             ras_pop;
    logic [XLEN-1:0]  ras_return_addr;
    logic             fetch_valid;
    logic [XLEN-1:0]  fetch_pc;
    logic [31:0]      fetch_instr;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    fetch_state_t     state;

    modport master (
        input  stall, redirect_valid, redirect_pc, instr_valid, imem_rdata,
               ras_valid, ras_predicted_return,
        output pc, ras_push, ras_pop, ras_return_addr, fetch_valid, fetch_pc,
               fetch_instr, pred_taken, pred_target, state
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, instr_valid, imem_rdata,
               ras_valid, ras_predicted_return,
        input  pc, ras_push, ras_pop, ras_return_addr, fetch_valid, fetch_pc,
               fetch_instr, pred_taken, pred_target, state
    );

endinterface

// File: rtl/fetch_pc_gen_cf_predecode.sv
// Combinational control-flow predecoder for one 32-bit instruction word.
//   instr   : raw instruction word
//   is_jal  : instruction is JAL
//   is_jalr : instruction is JALR (funct3 000)
//   push    : return address stack push hint
//   pop     : return address stack pop hint
//   j_imm   : sign-extended J-type immediate (valid when is_jal)
// Anything with instr[1:0] != 2'b11 (compressed) cannot match either opcode
// because both opcodes end in 2'b11, so it falls out as non-control.
module cf_predecode
    import riscv_pkg::*;
(
    input  logic [31:0]      instr,
    output logic             is_jal,
    output logic             is_jalr,
    output logic             push,
    output logic             pop,
    output logic [XLEN-1:0]  j_imm
);

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic       rd_link;
    logic       rs1_link;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rd_link  = is_link(rd);
    assign rs1_link = is_link(rs1);

    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR) && (funct3 == 3'b000);

    // J-type immediate: imm[20|10:1|11|19:12] packed into instr[31:12].
    assign j_imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20],
                    instr[30:21], 1'b0};

    // Any link destination means a call: push the return address.
    // A JALR whose source is a link register is a return: pop, except when
    // rd == rs1 (both links), which is a plain call reusing the register.
    always_comb begin
        push = 1'b0;
        pop  = 1'b0;
        if (is_jal) begin
            push = rd_link;
        end else if (is_jalr) begin
            push = rd_link;
            pop  = rs1_link && (!rd_link || (rs1 != rd));
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator with a small BOOT/RUN/DRAIN FSM, static JAL
// prediction and RAS-based return prediction.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : fetch_pc_gen_if.master (redirect, imem, RAS, fetch packet,
//             debug state)
// Priority each cycle: redirect > stall > accept > bubble.
module fetch_pc_gen
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_pc_gen_if.master bus
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;

    logic [XLEN-1:0] pc_q;
    logic            fetch_valid_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [31:0]     fetch_instr_q;
    logic            pred_taken_q;
    logic [XLEN-1:0] pred_target_q;

    logic            pd_is_jal;
    logic            pd_is_jalr;
    logic            pd_push;
    logic            pd_pop;
    logic [XLEN-1:0] pd_j_imm;

    logic            accept;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic            next_taken;
    logic [XLEN-1:0] next_target;

    cf_predecode u_predecode (
        .instr   (bus.imem_rdata),
        .is_jal  (pd_is_jal),
        .is_jalr (pd_is_jalr),
        .push    (pd_push),
        .pop     (pd_pop),
        .j_imm   (pd_j_imm)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // A redirect always lands in DRAIN so the stale imem response for the
    // old pc is dropped; a redirect during DRAIN simply restarts it.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = DRAIN;
        end else begin
            case (state_q)
                BOOT:    state_d = RUN;
                RUN:     state_d = RUN;
                DRAIN:   state_d = RUN;
                default: state_d = BOOT;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        accept = (state_q == RUN) && bus.instr_valid && !bus.stall &&
                 !bus.redirect_valid;
    end

    // ---------------- next-pc prediction ----------------
    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        next_pc    = pc_plus4;
        next_taken = 1'b0;
        if (pd_is_jal) begin
            next_pc    = pc_q + pd_j_imm;
            next_taken = 1'b1;
        end else if (pd_is_jalr && pd_pop && bus.ras_valid) begin
            next_pc    = bus.ras_predicted_return;
            next_taken = 1'b1;
        end
        next_target = next_taken ? next_pc : '0;
    end

    // RAS strobes are only meaningful for an instruction actually consumed.
    assign bus.ras_push        = accept && pd_push;
    assign bus.ras_pop         = accept && pd_pop;
    assign bus.ras_return_addr = (accept && pd_push) ? pc_plus4 : '0;

    // ---------------- pc and fetch packet ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_instr_q <= '0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else if (bus.redirect_valid) begin
            pc_q          <= bus.redirect_pc;
            fetch_valid_q <= 1'b0;
        end else if (state_q == RUN) begin
            if (accept) begin
                pc_q          <= next_pc;
                fetch_valid_q <= 1'b1;
                fetch_pc_q    <= pc_q;
                fetch_instr_q <= bus.imem_rdata;
                pred_taken_q  <= next_taken;
                pred_target_q <= next_target;
            end else if (!bus.stall) begin
                // No instruction this cycle: emit a bubble, keep pc.
                fetch_valid_q <= 1'b0;
            end
        end else begin
            // BOOT and DRAIN never produce a packet.
            fetch_valid_q <= 1'b0;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_pc    = fetch_pc_q;
    assign bus.fetch_instr = fetch_instr_q;
    assign bus.pred_taken  = pred_taken_q;
    assign bus.pred_target = pred_target_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: expected fetch packets are queued when an
// accepting cycle is driven and compared when the packet appears.
module tb_fetch_pc_gen;
    import riscv_pkg::*;

    localparam logic [31:0] NOP     = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] JAL_X1  = 32'h0400_00EF; // jal x1,+0x40
    localparam logic [31:0] RET     = 32'h0000_8067; // jalr x0,0(x1)
    localparam logic [31:0] JALR_X5 = 32'h0000_82E7; // jalr x5,0(x1)
    localparam int PKT_W = 97;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } pkt_t;

    logic clk;
    logic reset_n;

    fetch_pc_gen_if tb_if ();

    fetch_pc_gen #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (tb_if.master)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [PKT_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic accept_pending = 1'b0;
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_pkt(input logic [31:0] pc, input logic [31:0] instr,
                              input logic taken, input logic [31:0] target);
        pkt_t p;
        p.pc = pc; p.instr = instr; p.taken = taken; p.target = target;
        exp_q.push_back(p);
        accept_pending = 1'b1;
    endtask

    task automatic compare_pkt();
        pkt_t p;
        check("pkt_valid", 32'(tb_if.fetch_valid), 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL pkt_queue observed=empty expected=entry");
        end else begin
            p = exp_q.pop_front();
            check("pkt_pc", tb_if.fetch_pc, p.pc);
            check("pkt_instr", tb_if.fetch_instr, p.instr);
            check("pkt_taken", 32'(tb_if.pred_taken), 32'(p.taken));
            check("pkt_target", tb_if.pred_target, p.target);
        end
        accept_pending = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic iv, input logic [31:0] instr, input logic st,
                         input logic rv, input logic [31:0] rpc);
        tb_if.instr_valid    = iv;
        tb_if.imem_rdata     = instr;
        tb_if.stall          = st;
        tb_if.redirect_valid = rv;
        tb_if.redirect_pc    = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (accept_pending) compare_pkt();
    endtask

    task automatic accept_step(input string tag, input logic [31:0] instr,
                               input logic e_push, input logic e_pop,
                               input logic [31:0] e_ret, input logic e_taken,
                               input logic [31:0] e_next);
        drive(1'b1, instr, 1'b0, 1'b0, 32'h0);
        check({tag, "_push"}, 32'(tb_if.ras_push), 32'(e_push));
        check({tag, "_pop"}, 32'(tb_if.ras_pop), 32'(e_pop));
        check({tag, "_ret"}, tb_if.ras_return_addr, e_ret);
        expect_pkt(m_pc, instr, e_taken, e_taken ? e_next : 32'h0);
        tick();
        check({tag, "_next_pc"}, tb_if.pc, e_next);
        m_pc = e_next;
    endtask

    task automatic redirect_to(input logic [31:0] addr, input logic st);
        drive(1'b1, JAL_X1, st, 1'b1, addr);
        check("redir_push", 32'(tb_if.ras_push), 32'd0);
        tick();
        check("redir_pc", tb_if.pc, addr);
        check("redir_valid", 32'(tb_if.fetch_valid), 32'd0);
        check("redir_state", 32'(tb_if.state), 32'(DRAIN));
        m_pc = addr;
    endtask

    task automatic drain_step();
        drive(1'b1, JAL_X1, 1'b0, 1'b0, 32'h0);
        check("drain_push", 32'(tb_if.ras_push), 32'd0);
        tick();
        check("drain_pc", tb_if.pc, m_pc);
        check("drain_valid", 32'(tb_if.fetch_valid), 32'd0);
        check("drain_state", 32'(tb_if.state), 32'(RUN));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        tb_if.ras_valid = 1'b0;
        tb_if.ras_predicted_return = 32'h0;
        drive(1'b1, JAL_X1, 1'b0, 1'b0, 32'h0);
        #2;
        check("rst_pc", tb_if.pc, 32'h0);
        check("rst_state", 32'(tb_if.state), 32'(BOOT));
        check("rst_valid", 32'(tb_if.fetch_valid), 32'd0);
        check("rst_fpc", tb_if.fetch_pc, 32'h0);
        check("rst_instr", tb_if.fetch_instr, 32'h0);
        check("rst_taken", 32'(tb_if.pred_taken), 32'd0);
        check("rst_target", tb_if.pred_target, 32'h0);
        check("rst_push", 32'(tb_if.ras_push), 32'd0);

        // Release reset; the first cycle is BOOT: no strobe, no packet.
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("boot_push", 32'(tb_if.ras_push), 32'd0);
        tick();
        check("boot_pc", tb_if.pc, 32'h0);
        check("boot_valid", 32'(tb_if.fetch_valid), 32'd0);
        check("boot_state", 32'(tb_if.state), 32'(RUN));
        m_pc = 32'h0;

        // Sequential NOPs at 0x0, 0x4, 0x8.
        accept_step("nop0", NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4);
        accept_step("nop1", NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8);
        accept_step("nop2", NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'hC);

        // JAL x1,+0x40 at 0x100.
        redirect_to(32'h100, 1'b0);
        drain_step();
        accept_step("jal", JAL_X1, 1'b1, 1'b0, 32'h104, 1'b1, 32'h140);

        // Redirect during DRAIN reloads pc and stays in DRAIN.
        redirect_to(32'h300, 1'b0);
        redirect_to(32'h200, 1'b0);
        drain_step();
        tb_if.ras_valid = 1'b1;
        tb_if.ras_predicted_return = 32'h104;
        accept_step("ret_hit", RET, 1'b0, 1'b1, 32'h0, 1'b1, 32'h104);

        redirect_to(32'h200, 1'b0);
        drain_step();
        tb_if.ras_valid = 1'b0;
        accept_step("ret_miss", RET, 1'b0, 1'b1, 32'h0, 1'b0, 32'h204);

        // jalr x5,0(x1): push and pop together.
        accept_step("jalr_x5", JALR_X5, 1'b1, 1'b1, 32'h208, 1'b0, 32'h208);

        // Stall three cycles with a JAL presented: everything frozen.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, JAL_X1, 1'b1, 1'b0, 32'h0);
            check("stall_push", 32'(tb_if.ras_push), 32'd0);
            check("stall_pop", 32'(tb_if.ras_pop), 32'd0);
            tick();
            check("stall_pc", tb_if.pc, 32'h208);
            check("stall_valid", 32'(tb_if.fetch_valid), 32'd1);
            check("stall_fpc", tb_if.fetch_pc, 32'h204);
            check("stall_instr", tb_if.fetch_instr, JALR_X5);
        end
        redirect_to(32'h800, 1'b1);
        drain_step();
        accept_step("after_redir", NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h804);

        // No instruction available: bubble, pc held.
        drive(1'b0, NOP, 1'b0, 1'b0, 32'h0);
        tick();
        check("idle_pc", tb_if.pc, 32'h804);
        check("idle_valid", 32'(tb_if.fetch_valid), 32'd0);

        // Wrap-around of pc+4.
        redirect_to(32'hFFFF_FFFC, 1'b0);
        drain_step();
        accept_step("wrap", NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        accept_step("post_wrap", NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4);

        // Asynchronous reset mid-stream, away from any clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_pc", tb_if.pc, 32'h0);
        check("async_valid", 32'(tb_if.fetch_valid), 32'd0);
        check("async_state", 32'(tb_if.state), 32'(BOOT));
        check("async_fpc", tb_if.fetch_pc, 32'h0);
        check("async_push", 32'(tb_if.ras_push), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter: RESET_VECTOR, default 32'h0000_0000, first fetch PC after reset.
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: stall  input  1  downstream not ready; hold PC and fetch outputs.
REQ-005 Port: redirect_valid  input  1  backend redirect (mispredict/trap).
REQ-006 Port: redirect_pc  input  XLEN  redirect target.
REQ-007 Port: instr_valid  input  1  imem_rdata holds the instruction at pc this cycle.
REQ-008 Port: imem_rdata  input  32  instruction word at pc.
REQ-009 Port: ras_valid  input  1  RAS top entry valid.
REQ-010 Port: ras_predicted_return  input  XLEN  RAS top entry.
REQ-011 Port: pc  output  XLEN  current fetch address to instruction memory.
REQ-012 Port: ras_push / ras_pop  output  1 each  one-cycle RAS operation strobes.
REQ-013 Port: ras_return_addr  output  XLEN  value pushed (pc+4).
REQ-014 Port: fetch_valid  output  1  registered fetch packet valid to decode.
REQ-015 Port: fetch_pc / fetch_instr  output  XLEN / 32  registered PC and instruction.
REQ-016 Port: pred_taken / pred_target  output  1 / XLEN  registered prediction for the packet.

Function
REQ-017 FSM states BOOT, RUN, DRAIN; reset enters BOOT; BOOT -> RUN after one cycle with no packet and no RAS strobe.
REQ-018 Accept = state RUN && instr_valid && !stall && !redirect_valid.
REQ-019 On accept: pc <= next_pc; fetch_valid <= 1; fetch_pc <= pc; fetch_instr <= imem_rdata; pred_* <= predecode result.
REQ-020 RUN, !stall, !instr_valid, no redirect: pc held; fetch_valid <= 0.
REQ-021 stall (no redirect): pc, fetch_valid, fetch_pc, fetch_instr, pred_* all held; no RAS strobe.
REQ-022 redirect_valid: highest priority in any state, regardless of stall: pc <= redirect_pc, fetch_valid <= 0, no RAS strobe, state -> DRAIN.
REQ-023 DRAIN: one cycle, instr_valid ignored, fetch_valid <= 0, pc held; -> RUN; a redirect in DRAIN reloads pc and stays in DRAIN.
REQ-024 link(r) = r is x1 or x5; imem_rdata[1:0] != 2'b11 or any unlisted opcode -> non-control: next_pc = pc+4, pred_taken 0.
REQ-025 JAL (opcode 1101111): next_pc = pc + sext(J-imm); pred_taken 1; push if link(rd).
REQ-026 JALR (opcode 1100111, funct3 000), by rd/rs1: !link(rd)&&link(rs1) -> pop; link(rd)&&!link(rs1) -> push; both link, rs1==rd -> push; both link, rs1!=rd -> push and pop same cycle.
REQ-027 JALR with pop and ras_valid: next_pc = ras_predicted_return, pred_taken 1; otherwise next_pc = pc+4, pred_taken 0.
REQ-028 Conditional branches not predicted: next_pc = pc+4, pred_taken 0.
REQ-029 pred_target = next_pc when pred_taken else 0.
REQ-030 ras_push/ras_pop asserted only in an accept cycle, combinational from imem_rdata; ras_return_addr = pc+4 when ras_push, else 0.
REQ-031 All additions modulo 2^XLEN (0xFFFF_FFFC + 4 = 0); no misalignment checking.

Reset
REQ-032 On reset_n low, immediately: pc = RESET_VECTOR, state BOOT, fetch_valid 0, fetch_pc 0, fetch_instr 0, pred_taken 0, pred_target 0; ras_push/ras_pop 0 while reset asserted.
REQ-033 Reset mid-stall or mid-DRAIN discards all state; no strobe in the reset or BOOT cycle.

Structure
REQ-034 riscv_pkg holds XLEN, OP_JAL, OP_JALR, fetch_state_t (BOOT/RUN/DRAIN).
REQ-035 Classification and immediates in combinational sub-module cf_predecode (is_jal, is_jalr, push, pop, j_imm); FSM, PC and packet registers in fetch_pc_gen.

Verification
REQ-036 Reset release, RESET_VECTOR 0x0, instr_valid 1, NOPs -> cycle 1 BOOT no packet; fetch_pc 0x0, 0x4, 0x8 on consecutive cycles.
REQ-037 pc 0x100, JAL x1,+0x40 -> ras_push 1, ras_return_addr 0x104, next pc 0x140, pred_taken 1, pred_target 0x140.
REQ-038 pc 0x200, JALR x0,0(x1), ras_valid 1, ras_predicted_return 0x104 -> ras_pop 1, next pc 0x104; repeat with ras_valid 0 -> pop 1, next pc 0x204, pred_taken 0.
REQ-039 JALR x5,0(x1) -> ras_push and ras_pop same cycle, ras_return_addr pc+4.
REQ-040 stall 1 for 3 cycles with JAL at pc -> pc and packet frozen, no strobes; then redirect_valid with redirect_pc 0x800 while stalled -> pc 0x800, fetch_valid 0, one DRAIN cycle, next packet fetch_pc 0x800.
REQ-041 pc 0xFFFF_FFFC, NOP -> next pc 0x0; reset_n low mid-stream -> pc = RESET_VECTOR, fetch_valid 0 without a clock edge.
